// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared core types and constants for the fetch path.
//   XLEN          - architectural register / address width
//   INSTR_BYTES   - bytes per instruction (sequential PC increment)
//   fetch_entry_t - {instr, pc} pair handed from fetch to decode
package fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential successor; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO of fetch_entry_t between fetch and decode.
//   clk, rst_n  - clock, async active-low reset
//   push, wdata - enqueue wdata (caller guarantees room)
//   pop         - dequeue head; ignored while empty
//   flush       - drop all entries, reset pointers; overrides push/pop
//   head        - combinational read of the oldest entry (don't-care if empty)
//   count       - occupancy, 0..ENTRIES
//   empty       - count == 0
// ENTRIES must be a power of two >= 2 so pointers wrap naturally.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(ENTRIES):0]   count,
  output logic                       empty
);

  localparam int PW = $clog2(ENTRIES);
  localparam int CW = PW + 1;

  fetch_entry_t    store [ENTRIES];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) store[wptr] <= wdata;
  end

  assign head = store[rptr];

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(ENTRIES));
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count == CW'(ENTRIES)));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a synchronous imem.
//   clk, rst_n   - clock, async active-low reset
//   imemAddress  - byte PC to imem (combinational from the PC register)
//   imemInstr    - imem read data, valid one cycle after the address
//   redirect     - flush all younger state and restart at redirectPC
//   redirectPC   - word-aligned restart PC
//   deqReady     - decode takes the queue head this cycle
//   instrValid   - queue non-empty
//   instrOut     - instruction at the queue head
//   instrPC      - PC of the queue head
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ENTRIES  = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [XLEN-1:0]  imemAddress,
  input  logic [XLEN-1:0]  imemInstr,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirectPC,
  input  logic             deqReady,
  output logic             instrValid,
  output logic [XLEN-1:0]  instrOut,
  output logic [XLEN-1:0]  instrPC
);

  localparam int CW = $clog2(ENTRIES) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_valid;
  logic            issue;
  logic [CW:0]     used;
  logic [CW-1:0]   count;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    ret_entry;

  // Credit check counts the in-flight read as occupied and ignores a
  // same-cycle pop, so a returning read always finds a free slot.
  assign used  = {1'b0, count} + (CW+1)'(inflight_valid);
  assign issue = !redirect && (used < (CW+1)'(ENTRIES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      inflight_pc    <= RESET_PC;
      inflight_valid <= 1'b0;
    end else if (redirect) begin
      pc             <= redirectPC;
      inflight_valid <= 1'b0;
    end else if (issue) begin
      inflight_valid <= 1'b1;
      inflight_pc    <= pc;
      pc             <= next_pc(pc);
    end else begin
      // imem still reads pc this cycle; the data is simply never pushed.
      inflight_valid <= 1'b0;
    end
  end

  assign ret_entry = '{instr: imemInstr, pc: inflight_pc};

  fetch_queue #(
    .ENTRIES (ENTRIES)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_valid),
    .wdata (ret_entry),
    .pop   (deqReady),
    .flush (redirect),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign imemAddress = pc;
  assign instrValid  = !empty;
  assign instrOut    = head.instr;
  assign instrPC     = head.pc;

endmodule
